div_seq_ctrl: RTL

//  Sequencer for the iterative RV32M divider in the EXECUTE stage. Accepts the one-cycle
//  div_start pulse issued when a DIV/DIVU/REM/REMU enters EX and runs a radix-2

---
 rtl/rv_pkg.sv | 17 +
 rtl/div_seq_ctrl_if.sv | 22 ++
 rtl/div_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32M divider types
package rv_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// rtl/div_seq_ctrl_if.sv - EX-stage divider request/result bundle
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             div_start_e;
    logic [1:0]       div_ctrl_e;
    logic [WIDTH-1:0] op_a_e;
    logic [WIDTH-1:0] op_b_e;
    logic             div_stall;
    logic             div_done;
    logic [WIDTH-1:0] div_result;

    modport master (
        output div_start_e, div_ctrl_e, op_a_e, op_b_e,
        input  div_stall, div_done, div_result
    );

    modport slave (
        input  div_start_e, div_ctrl_e, op_a_e, op_b_e,
        output div_stall, div_done, div_result
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - radix-2 restoring divide sequencer for RV32M DIV/DIVU/REM/REMU
module div_seq_ctrl
    import rv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           cache_stall,
    div_seq_ctrl_if.slave  div_if
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
    logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    div_op_t          op_e;
    logic             sgn_op, rem_op;
    logic [WIDTH-1:0] a, b, abs_a, abs_b;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] quot_nx, rem_nx;

    assign op_e   = div_op_t'(div_if.div_ctrl_e);
    assign sgn_op = (op_e == DIV) || (op_e == REM);
    assign rem_op = (op_e == REM) || (op_e == REMU);
    assign a      = div_if.op_a_e;
    assign b      = div_if.op_b_e;
    assign abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

    // One restoring step; trial's top bit set means the subtraction borrowed.
    always_comb begin
        rem_sh = {rem_q, quot_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_q};
        if (!trial[WIDTH]) begin
            rem_nx  = trial[WIDTH-1:0];
            quot_nx = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh[WIDTH-1:0];
            quot_nx = {quot_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        is_rem_d  = is_rem_q;
        done_d    = done_q;
        result_d  = result_q;
        if (flush) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else if (!cache_stall) begin
            case (state_q)
                IDLE: begin
                    done_d = 1'b0;
                    if (div_if.div_start_e) begin
                        is_rem_d = rem_op;
                        q_neg_d  = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_d  = sgn_op && a[WIDTH-1];
                        // Special cases bypass the iteration and carry final values.
                        if (b == '0) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            quot_d   = '1;
                            rem_d    = a;
                            result_d = rem_op ? a : '1;
                        end else if (sgn_op && a == INT_MIN && b == '1) begin
                            state_d  = DONE;
                            done_d   = 1'b1;
                            quot_d   = a;
                            rem_d    = '0;
                            result_d = rem_op ? '0 : a;
                        end else begin
                            state_d   = CALC;
                            quot_d    = abs_a;
                            rem_d     = '0;
                            divisor_d = abs_b;
                            cnt_d     = CW'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    quot_d = quot_nx;
                    rem_d  = rem_nx;
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = is_rem_q ? (r_neg_q ? -rem_nx : rem_nx)
                                            : (q_neg_q ? -quot_nx : quot_nx);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            is_rem_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            is_rem_q  <= is_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign div_if.div_stall  = ((state_q == IDLE) && div_if.div_start_e) || (state_q == CALC);
    assign div_if.div_done   = done_q;
    assign div_if.div_result = result_q;

endmodule
